// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/interrupt/eret sequencer and CP0 write-port arbiter.
// Ports: MEM-stage exc/eret/mtc0 requests in; CP0 write port, kill/stall/flush/new_pc out.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        exc_req_i,
  input  logic [4:0]  exc_code_i,
  input  logic        eret_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  output logic        mtc0_ready_o,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        kill_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic [2:0] {
    IDLE,
    S_EPC,
    S_CAUSE,
    S_STATUS,
    S_ERET,
    S_REDIR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] tgt_q, tgt_d;

  logic int_p;
  logic exc_acc;
  logic eret_acc;

  assign int_p = status_i[0] & ~status_i[1]
               & (|(cause_i[15:8] & status_i[15:8]))
               & inst_valid_i;
  assign exc_acc  = int_p | (exc_req_i & inst_valid_i);
  assign eret_acc = eret_i & inst_valid_i & ~exc_acc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    code_d       = code_q;
    bd_d         = bd_q;
    tgt_d        = tgt_q;
    mtc0_ready_o = 1'b0;
    cp0_we_o     = 1'b0;
    cp0_waddr_o  = 5'd0;
    cp0_data_o   = 32'd0;
    kill_o       = 1'b0;
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    new_pc_o     = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (exc_acc) begin
          kill_o  = 1'b1;
          stall_o = 1'b1;
          code_d  = int_p ? 5'd0 : exc_code_i;
          bd_d    = in_delay_slot_i;
          pc_d    = in_delay_slot_i ? pc_i - 32'd4 : pc_i;
          tgt_d   = EXC_VECTOR;
          state_d = S_EPC;
        end else if (eret_acc) begin
          stall_o = 1'b1;
          tgt_d   = epc_i;
          state_d = S_ERET;
        end else if (mtc0_we_i) begin
          // Zero-latency passthrough; addr/data gated so idle is all-zero.
          mtc0_ready_o = 1'b1;
          cp0_we_o     = 1'b1;
          cp0_waddr_o  = mtc0_addr_i;
          cp0_data_o   = mtc0_data_i;
        end
      end
      S_EPC: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_EPC;
        cp0_data_o  = pc_q;
        stall_o     = 1'b1;
        state_d     = S_CAUSE;
      end
      S_CAUSE: begin
        // Live cause: keep IP and other bits, replace BD and ExcCode.
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_CAUSE;
        cp0_data_o  = {bd_q, cause_i[30:7], code_q, cause_i[1:0]};
        stall_o     = 1'b1;
        state_d     = S_STATUS;
      end
      S_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_data_o  = status_i | 32'h2;
        stall_o     = 1'b1;
        state_d     = S_REDIR;
      end
      S_ERET: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_data_o  = status_i & ~32'h2;
        stall_o     = 1'b1;
        state_d     = S_REDIR;
      end
      S_REDIR: begin
        flush_o  = 1'b1;
        new_pc_o = tgt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= 32'd0;
      code_q  <= 5'd0;
      bd_q    <= 1'b0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed bench for cp0_exc_ctrl.
// Drives inputs 1 ns after posedge, checks 1 ns later.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic        exc_req_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [31:0] pc_i;
  logic        in_delay_slot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        mtc0_we_i;
  logic [4:0]  mtc0_addr_i;
  logic [31:0] mtc0_data_i;
  logic        mtc0_ready_o;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        kill_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  int total = 0;
  int bad   = 0;

  // {we, flush, stall, kill, ready}
  logic [4:0] ctl;
  assign ctl = {cp0_we_o, flush_o, stall_o, kill_o, mtc0_ready_o};

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inst_valid_i    (inst_valid_i),
    .exc_req_i       (exc_req_i),
    .exc_code_i      (exc_code_i),
    .eret_i          (eret_i),
    .pc_i            (pc_i),
    .in_delay_slot_i (in_delay_slot_i),
    .status_i        (status_i),
    .cause_i         (cause_i),
    .epc_i           (epc_i),
    .mtc0_we_i       (mtc0_we_i),
    .mtc0_addr_i     (mtc0_addr_i),
    .mtc0_data_i     (mtc0_data_i),
    .mtc0_ready_o    (mtc0_ready_o),
    .cp0_we_o        (cp0_we_o),
    .cp0_waddr_o     (cp0_waddr_o),
    .cp0_data_o      (cp0_data_o),
    .kill_o          (kill_o),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req;
    inst_valid_i = 1'b0;
    exc_req_i    = 1'b0;
    eret_i       = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code,
                     input logic [31:0] pc,
                     input logic bd);
    inst_valid_i    = 1'b1;
    exc_req_i       = 1'b1;
    exc_code_i      = code;
    pc_i            = pc;
    in_delay_slot_i = bd;
  endtask

  initial begin
    rst = 1'b0;
    clr_req();
    exc_code_i = 5'd0;
    pc_i = 32'd0;
    in_delay_slot_i = 1'b0;
    status_i = 32'd0;
    cause_i = 32'd0;
    epc_i = 32'd0;
    mtc0_we_i = 1'b0;
    mtc0_addr_i = 5'd0;
    mtc0_data_i = 32'd0;
    nxt();
    nxt();
    #1;
    chk("rst_ctl", ctl, 5'b00000);
    chk("rst_pc", new_pc_o, 32'd0);
    chk("rst_addr", cp0_waddr_o, 32'd0);
    chk("rst_data", cp0_data_o, 32'd0);
    rst = 1'b1;

    // Syscall
    nxt();
    status_i = 32'h00000010;
    cause_i  = 32'h40000003;
    exc(5'd8, 32'h00400010, 1'b0);
    #1;
    chk("sys_acc_ctl", ctl, 5'b00110);
    nxt();
    clr_req();
    #1;
    chk("sys_epc_ctl", ctl, 5'b10100);
    chk("sys_epc_addr", cp0_waddr_o, 32'd14);
    chk("sys_epc_data", cp0_data_o, 32'h00400010);
    nxt();
    #1;
    chk("sys_cause_ctl", ctl, 5'b10100);
    chk("sys_cause_addr", cp0_waddr_o, 32'd13);
    chk("sys_cause_data", cp0_data_o, 32'h40000023);
    nxt();
    #1;
    chk("sys_stat_ctl", ctl, 5'b10100);
    chk("sys_stat_addr", cp0_waddr_o, 32'd12);
    chk("sys_stat_data", cp0_data_o, 32'h00000012);
    nxt();
    #1;
    chk("sys_redir_ctl", ctl, 5'b01000);
    chk("sys_redir_pc", new_pc_o, 32'hBFC00380);
    nxt();
    #1;
    chk("sys_idle_ctl", ctl, 5'b00000);

    // Delay-slot overflow at pc 0: EPC wraps
    cause_i = 32'h00000000;
    exc(5'd12, 32'h00000000, 1'b1);
    #1;
    chk("ov_acc_ctl", ctl, 5'b00110);
    nxt();
    clr_req();
    in_delay_slot_i = 1'b0;
    #1;
    chk("ov_epc_data", cp0_data_o, 32'hFFFFFFFC);
    nxt();
    #1;
    chk("ov_cause_data", cp0_data_o, 32'h80000030);
    nxt();
    nxt();
    #1;
    chk("ov_redir_ctl", ctl, 5'b01000);
    nxt();

    // Interrupt beats exception
    status_i = 32'h00000401;
    cause_i  = 32'h00000400;
    exc(5'd10, 32'h00000100, 1'b0);
    #1;
    chk("int_acc_ctl", ctl, 5'b00110);
    nxt();
    clr_req();
    #1;
    chk("int_epc_data", cp0_data_o, 32'h00000100);
    nxt();
    #1;
    chk("int_cause_data", cp0_data_o, 32'h00000400);
    nxt();
    #1;
    chk("int_stat_data", cp0_data_o, 32'h00000403);
    nxt();
    #1;
    chk("int_redir_pc", new_pc_o, 32'hBFC00380);
    nxt();

    // EXL set: no interrupt, code 10 taken
    status_i = 32'h00000403;
    exc(5'd10, 32'h00000200, 1'b0);
    #1;
    chk("ri_acc_ctl", ctl, 5'b00110);
    nxt();
    clr_req();
    nxt();
    #1;
    chk("ri_cause_data", cp0_data_o, 32'h00000428);
    nxt();
    nxt();
    #1;
    chk("ri_redir_ctl", ctl, 5'b01000);
    nxt();

    // Eret: target latched at accept
    status_i     = 32'h00000403;
    cause_i      = 32'h00000000;
    epc_i        = 32'h80001234;
    eret_i       = 1'b1;
    inst_valid_i = 1'b1;
    #1;
    chk("eret_acc_ctl", ctl, 5'b00100);
    nxt();
    clr_req();
    epc_i = 32'hDEADBEEF;
    #1;
    chk("eret_stat_ctl", ctl, 5'b10100);
    chk("eret_stat_addr", cp0_waddr_o, 32'd12);
    chk("eret_stat_data", cp0_data_o, 32'h00000401);
    nxt();
    #1;
    chk("eret_redir_ctl", ctl, 5'b01000);
    chk("eret_redir_pc", new_pc_o, 32'h80001234);
    nxt();
    #1;
    chk("eret_idle_ctl", ctl, 5'b00000);

    // mtc0 passthrough in idle
    status_i    = 32'h00000010;
    mtc0_we_i   = 1'b1;
    mtc0_addr_i = 5'd11;
    mtc0_data_i = 32'hCAFEF00D;
    #1;
    chk("mtc_ctl", ctl, 5'b10001);
    chk("mtc_addr", cp0_waddr_o, 32'd11);
    chk("mtc_data", cp0_data_o, 32'hCAFEF00D);
    nxt();

    // mtc0 blocked in accept cycle and mid-sequence; reset in S_CAUSE
    exc(5'd8, 32'h00400020, 1'b0);
    #1;
    chk("mtc_acc_ctl", ctl, 5'b00110);
    nxt();
    clr_req();
    #1;
    chk("mtc_epc_ctl", ctl, 5'b10100);
    nxt();
    #1;
    chk("mtc_cause_ctl", ctl, 5'b10100);
    chk("mtc_cause_addr", cp0_waddr_o, 32'd13);
    rst = 1'b0;
    mtc0_we_i = 1'b0;
    nxt();
    #1;
    chk("mrst_ctl", ctl, 5'b00000);
    chk("mrst_pc", new_pc_o, 32'd0);
    rst = 1'b1;
    nxt();
    #1;
    chk("mrst_nostat", ctl, 5'b00000);
    nxt();
    #1;
    chk("mrst_noflush", ctl, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
